// File: rtl/regwr_pkg.sv
// Shared register-file write definitions: address/data widths and the
// last-grant encoding used by the write arbiter.
package regwr_pkg;
  localparam int REG_AW   = 4;
  localparam int REG_DW   = 8;
  localparam int NUM_REGS = 16;

  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } last_t;
endpackage

// File: rtl/wrfifo.sv
// Per-requester write FIFO with a per-entry valid/address view so the
// arbiter can build its register busy map.
module wrfifo
  import regwr_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [REG_AW-1:0]             in_addr,
  input  logic [REG_DW-1:0]             in_data,
  output logic                          full,
  output logic                          empty,
  output logic [REG_AW-1:0]             head_addr,
  output logic [REG_DW-1:0]             head_data,
  output logic [DEPTH-1:0]              ent_valid,
  output logic [DEPTH-1:0][REG_AW-1:0]  ent_addr
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [REG_AW-1:0] mem_addr [DEPTH];
  logic [REG_DW-1:0] mem_data [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_addr[wr_ptr] <= in_addr;
      mem_data[wr_ptr] <= in_data;
    end
  end

  assign head_addr = mem_addr[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  // A slot is live when its distance from the read pointer is below count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_view
    assign ent_valid[g] = ({1'b0, PW'(g) - rd_ptr} < count);
    assign ent_addr[g]  = mem_addr[g];
  end
endmodule

// File: rtl/regwr_arbiter.sv
// Two-requester register-file write arbiter. Define REGWR_ARBITER_RR_EN for
// round-robin arbitration; otherwise requester 0 has fixed priority.
module regwr_arbiter
  import regwr_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                r0_valid,
  input  logic [REG_AW-1:0]   r0_addr,
  input  logic [REG_DW-1:0]   r0_data,
  output logic                r0_ready,
  input  logic                r1_valid,
  input  logic [REG_AW-1:0]   r1_addr,
  input  logic [REG_DW-1:0]   r1_data,
  output logic                r1_ready,
  output logic                we3,
  output logic [REG_AW-1:0]   wa3,
  output logic [REG_DW-1:0]   wd3,
  output logic [NUM_REGS-1:0] busy
);
  logic                         full0, full1, empty0, empty1;
  logic [REG_AW-1:0]            h0_addr, h1_addr;
  logic [REG_DW-1:0]            h0_data, h1_data;
  logic [DEPTH-1:0]             v0, v1;
  logic [DEPTH-1:0][REG_AW-1:0] a0, a1;
  logic                         any, gnt1;

  assign r0_ready = !full0;
  assign r1_ready = !full1;
  assign any      = !(empty0 && empty1);

  wrfifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .reset(reset),
    .push(r0_valid && r0_ready), .pop(any && !gnt1),
    .in_addr(r0_addr), .in_data(r0_data),
    .full(full0), .empty(empty0),
    .head_addr(h0_addr), .head_data(h0_data),
    .ent_valid(v0), .ent_addr(a0)
  );

  wrfifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .reset(reset),
    .push(r1_valid && r1_ready), .pop(any && gnt1),
    .in_addr(r1_addr), .in_data(r1_data),
    .full(full1), .empty(empty1),
    .head_addr(h1_addr), .head_data(h1_data),
    .ent_valid(v1), .ent_addr(a1)
  );

`ifdef REGWR_ARBITER_RR_EN
  last_t state, state_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LAST1;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!empty0 && !empty1) gnt1 = (state == LAST0);
    else                    gnt1 = !empty1;
    if (any) state_nxt = gnt1 ? LAST1 : LAST0;
  end
`else
  always_comb gnt1 = empty0 && !empty1;
`endif

  // Address 0 still consumes the grant and pops, but never writes.
  always_comb begin
    we3 = 1'b0;
    wa3 = '0;
    wd3 = '0;
    if (any) begin
      wa3 = gnt1 ? h1_addr : h0_addr;
      wd3 = gnt1 ? h1_data : h0_data;
      we3 = (wa3 != '0);
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (v0[i]) busy[a0[i]] = 1'b1;
      if (v1[i]) busy[a1[i]] = 1'b1;
    end
    busy[0] = 1'b0;
  end
endmodule

// File: doc/regwr_arbiter.md
REGWR_ARBITER -- requirements
Module: regwr_arbiter

Interface
REQ-001 Parameter: DEPTH, 2, entries per requester write FIFO (power of two, >=2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 r0_valid  input  1  requester 0 write request valid.
REQ-005 r0_addr  input  4  requester 0 destination register.
REQ-006 r0_data  input  8  requester 0 write data.
REQ-007 r0_ready  output  1  requester 0 FIFO can accept.
REQ-008 r1_valid / r1_addr / r1_data / r1_ready SHALL mirror REQ-004..007 for requester 1.
REQ-009 we3  output  1  register-file write enable.
REQ-010 wa3  output  4  register-file write address.
REQ-011 wd3  output  8  register-file write data.
REQ-012 busy  output  16  bit i high while any queued entry targets register i.

Function
REQ-013 Transfer on rN_valid && rN_ready at rising edge; entry pushed into requester N FIFO.
REQ-014 rN_ready = !fullN; no push-through when full, even if head pops same cycle.
REQ-015 Arbiter SHALL issue at most one write per cycle, combinationally from FIFO heads; granted head pops on the edge that performs the write.
REQ-016 Minimum latency: entry accepted at edge N SHALL be written to the register file at edge N+1.
REQ-017 Arbiter state: LAST0 / LAST1 (last granted requester); reset state LAST1 so requester 0 wins the first conflict.
REQ-018 Only one FIFO non-empty: grant it; state -> LAST<that requester>.
REQ-019 Both non-empty: grant requester opposite to last grant (see REQ-027 for no-macro build); state -> LAST<granted>.
REQ-020 Both empty: we3=0, wa3=0, wd3=0, state held.
REQ-021 Entry with addr 0: granted and popped normally but we3 SHALL be 0 that cycle (write dropped, still consumes arbitration slot).
REQ-022 Per-requester order SHALL be preserved; cross-requester order to the same register follows grant order only.
REQ-023 busy[0] SHALL always be 0; busy[i] computed combinationally over all valid entries of both FIFOs.
REQ-024 Simultaneous push and pop on the same FIFO (not full) SHALL keep count unchanged and preserve order; pointers wrap modulo DEPTH.

Reset
REQ-025 reset SHALL immediately empty both FIFOs, force state LAST1, drive r0_ready=r1_ready=1, we3=0, wa3=0, wd3=0, busy=0; queued entries discarded, including mid-operation.
REQ-026 FIFO storage contents need not be cleared; only pointers/counts.

Configuration
REQ-027 Macro REGWR_ARBITER_RR_EN: defined -> round-robin per REQ-019; undefined -> fixed priority, requester 0 always wins when both non-empty and LAST state register omitted.

Structure
REQ-028 Shared package/header regwr_pkg SHALL hold REG_AW=4, REG_DW=8, NUM_REGS=16 and state encodings LAST0=1'b0, LAST1=1'b1.
REQ-029 Sub-module wrfifo (push/pop/full/empty, head addr/data, per-entry valid+addr view for busy) SHALL be instantiated twice.

Verification
REQ-030 Reset then r0 writes (addr 3, 0xA5) at edge 1 -> we3=1, wa3=3, wd3=0xA5 during cycle after edge 1; busy=0x0008 same cycle; busy=0 after edge 2.
REQ-031 Both requesters push every cycle (r0 addr 1, r1 addr 2) -> with RR_EN grants alternate r0,r1,r0,...; without it r0 granted until its FIFO empties, r1 starved.
REQ-032 r0 pushes 3 entries, no pops possible (r1 saturating in fixed-priority build not required; use stalled RR with DEPTH=2 and both full) -> r0_ready=0 after 2 accepted; third held until a pop frees space.
REQ-033 r1 writes addr 0 data 0xFF -> entry popped, we3=0 that cycle, busy unchanged (bit 0 stays 0).
REQ-034 Both FIFOs full, assert reset mid-cycle -> outputs to reset values asynchronously; after release, no queued write is ever issued.
REQ-035 Same address 5 from r0 (0x11) and r1 (0x22) same edge, RR_EN, fresh reset -> r0 written first, register 5 ends 0x22.
